// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs mnemonic + operands into ISA words
// and streams them into instruction memory, flagging out-of-range fields.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;
  typedef enum logic [2:0] {K_R, K_SH, K_IRD, K_IRS, K_J, K_BAD} kind_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_t      state, state_nx;
  kind_t       kind;
  logic [3:0]  mnem_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [31:0] imm_q, word, word_q;
  logic [5:0]  op, fn;
  logic [1:0]  chk;
  logic        rng_ok, fire;
  logic        s16_ok, u16_ok, u5_ok, u26_ok;

  assign full       = word_count == DEPTH_C;
  assign in_ready   = !rst && state == IDLE && !full && !clear;
  assign fire       = in_valid && in_ready;
  assign imem_we    = state == WR && !clear;
  assign imem_addr  = BASE_C + word_count[ADDR_W-1:0];
  assign imem_wdata = word_q;

  assign s16_ok = imm_q[31:15] == '0 || imm_q[31:15] == '1;
  assign u16_ok = imm_q[31:16] == '0;
  assign u5_ok  = imm_q[31:5] == '0;
  assign u26_ok = imm_q[31:26] == '0;

  always_comb begin
    op     = 6'b000000;
    fn     = 6'b000000;
    kind   = K_BAD;
    rng_ok = 1'b1;
    unique case (mnem_q)
      4'd0:  begin op = 6'b000000; fn = 6'b000001; kind = K_R; end
      4'd1:  begin op = 6'b000001; fn = 6'b000001; kind = K_R; end
      4'd2:  begin op = 6'b000001; fn = 6'b000010; kind = K_R; end
      4'd3:  begin op = 6'b000001; fn = 6'b000100; kind = K_R; end
      4'd4:  begin
        op = 6'b000010; fn = 6'b000010; kind = K_SH; rng_ok = u5_ok;
      end
      4'd5:  begin
        op = 6'b000010; fn = 6'b000011; kind = K_SH; rng_ok = u5_ok;
      end
      4'd6:  begin op = 6'b000101; kind = K_IRD; rng_ok = s16_ok; end
      4'd7:  begin op = 6'b001001; kind = K_IRD; rng_ok = u16_ok; end
      4'd8:  begin op = 6'b001010; kind = K_IRD; rng_ok = u16_ok; end
      4'd9:  begin op = 6'b001100; kind = K_IRD; rng_ok = u16_ok; end
      4'd10: begin op = 6'b001101; kind = K_IRD; rng_ok = s16_ok; end
      4'd11: begin op = 6'b001110; kind = K_IRS; rng_ok = s16_ok; end
      4'd12: begin op = 6'b001111; kind = K_IRS; rng_ok = s16_ok; end
      4'd13: begin op = 6'b010000; kind = K_IRS; rng_ok = s16_ok; end
      4'd14: begin op = 6'b010010; kind = K_J;   rng_ok = u26_ok; end
      default: kind = K_BAD;
    endcase
  end

  always_comb begin
    word = '0;
    chk  = 2'b00;
    unique case (kind)
      K_R:   word = {op, rs1_q, rs2_q, rd_q, 5'b0, fn};
      K_SH:  word = {op, imm_q[4:0], rs2_q, rd_q, 5'b0, fn};
      K_IRD: word = {op, rs1_q, rd_q, imm_q[15:0]};
      K_IRS: word = {op, rs1_q, rs2_q, imm_q[15:0]};
      K_J:   word = {op, imm_q[25:0]};
      default: word = '0;
    endcase
    // invalid mnemonic outranks any range failure
    if (kind == K_BAD)
      chk = 2'b01;
    else if (!rng_ok)
      chk = (kind == K_SH || kind == K_J) ? 2'b11 : 2'b10;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (fire) state_nx = ENC;
      ENC:     state_nx = (chk == 2'b00) ? WR : IDLE;
      WR:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mnem_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      word_q     <= '0;
      word_count <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      err_addr   <= '0;
    end else begin
      state <= state_nx;
      if (clear) begin
        word_count <= '0;
        err        <= 1'b0;
        err_code   <= 2'b00;
        err_addr   <= '0;
      end else begin
        if (fire) begin
          mnem_q <= in_mnem;
          rd_q   <= in_rd;
          rs1_q  <= in_rs1;
          rs2_q  <= in_rs2;
          imm_q  <= in_imm;
        end
        if (state == ENC) begin
          if (chk == 2'b00) begin
            word_q <= word;
          end else begin
            err <= 1'b1;
            if (!err) begin
              err_code <= chk;
              err_addr <= imem_addr;
            end
          end
        end
        if (state == WR)
          word_count <= word_count + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, range errors, full,
// clear and asynchronous reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_mnem = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;
  logic        full, err;
  logic [1:0]  err_code;
  logic [7:0]  err_addr;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  int we_snap;

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) we_cnt++;

  instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count),
    .full(full), .err(err), .err_code(err_code),
    .err_addr(err_addr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] m, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit exp_wr,
                      input logic [7:0] exp_addr,
                      input logic [31:0] exp_data, input string tag);
    int n;
    @(negedge clk);
    in_mnem = m; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_enc_we"}, 32'(imem_we), 32'd0);
    @(negedge clk);
    check({tag, "_we"}, 32'(imem_we), 32'(exp_wr));
    if (exp_wr) begin
      check({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
      check({tag, "_data"}, imem_wdata, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_ready", 32'(in_ready), 32'd1);

    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 8'd0, 32'h00221801, "add");
    check("add_count", 32'(word_count), 32'd1);
    send(4'd6, 5'd5, 5'd0, 5'd0, -32'sd4, 1, 8'd1, 32'h1405FFFC, "addi");
    send(4'd5, 5'd4, 5'd0, 5'd6, 32'd3, 1, 8'd2, 32'h08662003, "sll");
    send(4'd14, 5'd0, 5'd0, 5'd0, 32'h40, 1, 8'd3, 32'h48000040, "j");
    check("full_count", 32'(word_count), 32'd4);
    check("full_flag", 32'(full), 32'd1);

    we_snap = we_cnt;
    @(negedge clk);
    in_mnem = 4'd0; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("full_ready", 32'(in_ready), 32'd0);
    end
    check("full_no_we", 32'(we_cnt), 32'(we_snap));
    clear = 1'b1;
    #1 check("clr_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 begin clear = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    check("clr_count", 32'(word_count), 32'd0);
    check("clr_full", 32'(full), 32'd0);
    check("clr_ready1", 32'(in_ready), 32'd1);

    send(4'd3, 5'd1, 5'd2, 5'd3, 32'd0, 1, 8'd0, 32'h04430804, "xor");
    send(4'd8, 5'd1, 5'd1, 5'd0, 32'h10000, 0, 8'd0, 32'd0, "ori_big");
    check("e1_err", 32'(err), 32'd1);
    check("e1_code", 32'(err_code), 32'd2);
    check("e1_addr", 32'(err_addr), 32'd1);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 8'd1, 32'h00221801, "add2");
    send(4'd8, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 0, 8'd0, 32'd0, "ori_neg");
    send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 0, 8'd0, 32'd0, "bad_sticky");
    check("e2_code", 32'(err_code), 32'd2);
    check("e2_addr", 32'(err_addr), 32'd1);
    check("e2_count", 32'(word_count), 32'd2);

    we_snap = we_cnt;
    @(negedge clk);
    in_mnem = 4'd10; in_rd = 5'd4; in_rs1 = 5'd2;
    in_imm = 32'd8; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(imem_we), 32'd0);
    check("arst_count", 32'(word_count), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_code", 32'(err_code), 32'd0);
    check("arst_addr", 32'(imem_addr), 32'd0);
    check("arst_wdata", imem_wdata, 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_no_we", 32'(we_cnt), 32'(we_snap));

    send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 0, 8'd0, 32'd0, "bad");
    check("bad_code", 32'(err_code), 32'd1);
    check("bad_addr", 32'(err_addr), 32'd0);
    pulse_clear();
    send(4'd4, 5'd1, 5'd0, 5'd2, 32'd32, 0, 8'd0, 32'd0, "srl_big");
    check("sh_code", 32'(err_code), 32'd3);
    pulse_clear();
    send(4'd14, 5'd0, 5'd0, 5'd0, 32'h4000000, 0, 8'd0, 32'd0, "j_big");
    check("j_code", 32'(err_code), 32'd3);
    pulse_clear();
    check("clr_err", 32'(err), 32'd0);
    send(4'd7, 5'd8, 5'd7, 5'd0, 32'hFFFF, 1, 8'd0, 32'h24E8FFFF, "andi");
    send(4'd12, 5'd0, 5'd1, 5'd2, 32'hFFFF8000, 1, 8'd1, 32'h3C228000,
         "beq_min");
    send(4'd12, 5'd0, 5'd1, 5'd2, 32'hFFFF7FFF, 0, 8'd0, 32'd0,
         "beq_low");
    check("beq_code", 32'(err_code), 32'd2);
    check("beq_addr", 32'(err_addr), 32'd2);

    we_snap = we_cnt;
    @(negedge clk);
    in_mnem = 4'd11; in_rs1 = 5'd2; in_rs2 = 5'd9;
    in_imm = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    #1 check("wrclr_we", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("wrclr_count", 32'(word_count), 32'd0);
    check("wrclr_no_we", 32'(we_cnt), 32'(we_snap));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
